// File: rtl/adder_pipe_if.sv
// Handshake and payload bundle for adder_pipe: operand beat in, result beat out.
interface adder_pipe_if #(
    parameter int N = 32
) ();
    logic         in_valid;
    logic         in_ready;
    logic [N-1:0] a;
    logic [N-1:0] b;
    logic         cin;
    logic         sub;
    logic         sat;
    logic         out_valid;
    logic         out_ready;
    logic [N-1:0] y;
    logic         cout;
    logic         ovf;
    logic         zero;
    logic         neg;

    // Producer/consumer side that drives operands and accepts results.
    modport master (
        output in_valid, a, b, cin, sub, sat, out_ready,
        input  in_ready, out_valid, y, cout, ovf, zero, neg
    );

    // The adder itself.
    modport slave (
        input  in_valid, a, b, cin, sub, sat, out_ready,
        output in_ready, out_valid, y, cout, ovf, zero, neg
    );
endinterface

// File: rtl/adder_pipe.sv
// Pipelined add/subtract with optional signed saturation.
// The N-bit carry chain is split into K chunks of W = N/K bits; chunk i is
// added in stage i using the carry registered by stage i-1. Operands travel
// whole with the beat, completed chunks accumulate in a partial-sum register,
// and the last stage produces the saturated result and flags.
// One global advance signal (adv) freezes every stage on output back-pressure.
module adder_pipe #(
    parameter int N = 32,
    parameter int K = 4
) (
    input logic         clk,
    input logic         rst_n,
    adder_pipe_if.slave bus
);
    localparam int W = N / K;

    localparam logic signed [N-1:0] SAT_MAX = {1'b0, {(N-1){1'b1}}};
    localparam logic signed [N-1:0] SAT_MIN = {1'b1, {(N-1){1'b0}}};

    // Two's-complement overflow from the operand and sum sign bits.
    function automatic logic signed_ovf(input logic a_sign, input logic b_sign,
                                        input logic s_sign);
        return (a_sign & b_sign & ~s_sign) | (~a_sign & ~b_sign & s_sign);
    endfunction

    // Clamp to the signed range when saturation is requested and the raw
    // sum overflowed; the direction of overflow follows the sign of a.
    function automatic logic signed [N-1:0] saturate(input logic signed [N-1:0] s,
                                                     input logic ovf,
                                                     input logic sat,
                                                     input logic a_sign);
        if (sat && ovf) begin
            return a_sign ? SAT_MIN : SAT_MAX;
        end
        return s;
    endfunction

    // Output registers (last pipeline stage).
    logic         out_valid_r;
    logic [N-1:0] y_r;
    logic         cout_r;
    logic         ovf_r;
    logic         zero_r;
    logic         neg_r;

    // Whole pipeline moves together; it only stops when a result sits
    // unconsumed at the output.
    logic adv;
    assign adv          = ~out_valid_r | bus.out_ready;
    assign bus.in_ready = adv;

    assign bus.out_valid = out_valid_r;
    assign bus.y         = y_r;
    assign bus.cout      = cout_r;
    assign bus.ovf       = ovf_r;
    assign bus.zero      = zero_r;
    assign bus.neg       = neg_r;

    // What each stage sees as its input (the bus for stage 0, otherwise the
    // registers of the stage before it).
    logic         src_vld    [K];
    logic         src_c      [K];
    logic         src_sub    [K];
    logic         src_sat    [K];
    logic [N-1:0] src_a      [K];
    logic [N-1:0] src_b      [K];
    logic [N-1:0] src_s      [K];

    // Per-stage chunk arithmetic.
    logic [W-1:0] beff_chunk [K];
    logic [W-1:0] sum_chunk  [K];
    logic         carry_out  [K];
    logic [N-1:0] s_next     [K];

    // Inter-stage registers; entry K-1 is unused because the last stage
    // writes straight into the output registers.
    logic         vld_p      [K];
    logic         carry_p    [K];
    logic         sub_p      [K];
    logic         sat_p      [K];
    logic [N-1:0] a_p        [K];
    logic [N-1:0] b_p        [K];
    logic [N-1:0] s_p        [K];

    for (genvar i = 0; i < K; i++) begin : g_stage
        localparam logic [N-1:0] CHUNK_MASK = {{(N-W){1'b0}}, {W{1'b1}}} << (i * W);

        if (i == 0) begin : g_src_bus
            // Subtraction forces the carry-in to 1 and ignores cin.
            assign src_vld[i] = bus.in_valid;
            assign src_c[i]   = bus.sub ? 1'b1 : bus.cin;
            assign src_sub[i] = bus.sub;
            assign src_sat[i] = bus.sat;
            assign src_a[i]   = bus.a;
            assign src_b[i]   = bus.b;
            assign src_s[i]   = '0;
        end else begin : g_src_reg
            assign src_vld[i] = vld_p[i-1];
            assign src_c[i]   = carry_p[i-1];
            assign src_sub[i] = sub_p[i-1];
            assign src_sat[i] = sat_p[i-1];
            assign src_a[i]   = a_p[i-1];
            assign src_b[i]   = b_p[i-1];
            assign src_s[i]   = s_p[i-1];
        end

        // b is inverted chunk by chunk, using the sub bit carried with the beat.
        assign beff_chunk[i] = src_sub[i] ? ~src_b[i][i*W +: W] : src_b[i][i*W +: W];

        assign {carry_out[i], sum_chunk[i]} = {1'b0, src_a[i][i*W +: W]}
                                            + {1'b0, beff_chunk[i]}
                                            + {{W{1'b0}}, src_c[i]};

        // Drop this stage's chunk into its slot of the partial sum.
        assign s_next[i] = (src_s[i] & ~CHUNK_MASK)
                         | (({{(N-W){1'b0}}, sum_chunk[i]}) << (i * W));

        if (i < K - 1) begin : g_mid
            // Stage i valid bit: the only reset state in the middle stages.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    vld_p[i] <= 1'b0;
                end else if (adv) begin
                    vld_p[i] <= src_vld[i];
                end
            end

            // Stage i payload: carry, control bits, operands and partial sum.
            always_ff @(posedge clk) begin
                if (adv) begin
                    carry_p[i] <= carry_out[i];
                    sub_p[i]   <= src_sub[i];
                    sat_p[i]   <= src_sat[i];
                    a_p[i]     <= src_a[i];
                    b_p[i]     <= src_b[i];
                    s_p[i]     <= s_next[i];
                end
            end
        end else begin : g_last
            logic         a_sign;
            logic         b_sign;
            logic         ovf_raw;
            logic [N-1:0] y_next;

            // Sign bits come from the top chunk, which only this stage consumes.
            assign a_sign  = src_a[i][N-1];
            assign b_sign  = beff_chunk[i][W-1];
            assign ovf_raw = signed_ovf(a_sign, b_sign, s_next[i][N-1]);
            assign y_next  = saturate(s_next[i], ovf_raw, src_sat[i], a_sign);

            // Output stage: result, raw carry/overflow and flags of the final value.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    out_valid_r <= 1'b0;
                    y_r         <= '0;
                    cout_r      <= 1'b0;
                    ovf_r       <= 1'b0;
                    zero_r      <= 1'b0;
                    neg_r       <= 1'b0;
                end else if (adv) begin
                    out_valid_r <= src_vld[i];
                    y_r         <= y_next;
                    cout_r      <= carry_out[i];
                    ovf_r       <= ovf_raw;
                    zero_r      <= (y_next == '0);
                    neg_r       <= y_next[N-1];
                end
            end
        end
    end
endmodule

// File: tb/tb_adder_pipe.sv
// Randomized and directed bench for adder_pipe (N = 32, K = 4) with a
// scoreboard fed by an arithmetic reference model.
module tb_adder_pipe;
    localparam int N = 32;
    localparam int K = 4;

    logic clk = 1'b0;
    logic rst_n;

    always #5 clk = ~clk;

    adder_pipe_if #(.N(N)) bus ();

    adder_pipe #(.N(N), .K(K)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    typedef struct {
        logic [31:0] y;
        logic        cout;
        logic        ovf;
        logic        zero;
        logic        neg;
        int          acc;
        int          stalls;
    } exp_t;

    exp_t q[$];

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    int stalls   = 0;
    int n_out    = 0;

    logic        hold_pend = 1'b0;
    logic [31:0] held_y;
    logic        held_cout, held_ovf, held_zero, held_neg;

    logic [31:0] last_y;
    logic        last_cout, last_ovf, last_zero, last_neg;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    // Reference: true signed result decides overflow and clamping; the raw
    // carry is the bit above N of a + (b or ~b) + carry-in.
    function automatic exp_t model(input logic [31:0] a, input logic [31:0] b,
                                   input logic cin, input logic sub, input logic sat);
        exp_t        e;
        longint      sa, sb, r;
        logic [32:0] raw;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        r  = sub ? (sa - sb) : (sa + sb + longint'(cin));
        e.ovf = (r > 64'sd2147483647) || (r < -64'sd2147483648);
        raw = sub ? ({1'b0, a} + {1'b0, ~b} + 33'd1)
                  : ({1'b0, a} + {1'b0, b} + {32'd0, cin});
        e.cout = raw[32];
        if (sat && e.ovf) e.y = (r > 0) ? 32'h7FFF_FFFF : 32'h8000_0000;
        else              e.y = r[31:0];
        e.zero   = (e.y == 32'd0);
        e.neg    = e.y[31];
        e.acc    = 0;
        e.stalls = 0;
        return e;
    endfunction

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 7))
            0: return 32'h7FFF_FFFF;
            1: return 32'h8000_0000;
            2: return 32'hFFFF_FFFF;
            3: return 32'h0000_0000;
            4: return 32'h0000_0001;
            default: return $urandom;
        endcase
    endfunction

    // One clock: drive inputs at the falling edge, observe, score, advance.
    task automatic cycle(input logic iv, input logic [31:0] a, input logic [31:0] b,
                         input logic cin, input logic sub, input logic sat,
                         input logic ordy, output logic accepted);
        logic exp_rdy;
        exp_t e;
        bus.in_valid  = iv;
        bus.a         = a;
        bus.b         = b;
        bus.cin       = cin;
        bus.sub       = sub;
        bus.sat       = sat;
        bus.out_ready = ordy;
        #1;
        if (hold_pend) begin
            check_eq("hold_valid", 64'(bus.out_valid), 64'd1);
            check_eq("hold_y",     64'(bus.y),    64'(held_y));
            check_eq("hold_cout",  64'(bus.cout), 64'(held_cout));
            check_eq("hold_ovf",   64'(bus.ovf),  64'(held_ovf));
            check_eq("hold_zero",  64'(bus.zero), 64'(held_zero));
            check_eq("hold_neg",   64'(bus.neg),  64'(held_neg));
        end
        exp_rdy = !bus.out_valid || ordy;
        check_eq("in_ready", 64'(bus.in_ready), 64'(exp_rdy));
        hold_pend = 1'b0;
        if (bus.out_valid && !ordy) begin
            stalls++;
            hold_pend = 1'b1;
            held_y    = bus.y;
            held_cout = bus.cout;
            held_ovf  = bus.ovf;
            held_zero = bus.zero;
            held_neg  = bus.neg;
        end
        if (bus.out_valid && ordy) begin
            if (q.size() == 0) begin
                check_eq("spurious_out", 64'(bus.out_valid), 64'd0);
            end else begin
                e = q.pop_front();
                check_eq("y",    64'(bus.y),    64'(e.y));
                check_eq("cout", 64'(bus.cout), 64'(e.cout));
                check_eq("ovf",  64'(bus.ovf),  64'(e.ovf));
                check_eq("zero", 64'(bus.zero), 64'(e.zero));
                check_eq("neg",  64'(bus.neg),  64'(e.neg));
                if (e.stalls == stalls) check_eq("latency", 64'(cyc - e.acc), 64'(K));
                last_y    = bus.y;
                last_cout = bus.cout;
                last_ovf  = bus.ovf;
                last_zero = bus.zero;
                last_neg  = bus.neg;
                n_out++;
            end
        end
        accepted = iv && exp_rdy;
        if (accepted) begin
            e        = model(a, b, cin, sub, sat);
            e.acc    = cyc;
            e.stalls = stalls;
            q.push_back(e);
        end
        @(negedge clk);
        cyc++;
    endtask

    task automatic idle();
        logic acc;
        cycle(1'b0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b1, acc);
    endtask

    task automatic drain();
        int guard = 0;
        while (q.size() != 0 && guard < 40) begin
            idle();
            guard++;
        end
        check_eq("drain", 64'(q.size()), 64'd0);
        idle();
    endtask

    task automatic run_one(input logic [31:0] a, input logic [31:0] b,
                           input logic cin, input logic sub, input logic sat);
        logic acc;
        cycle(1'b1, a, b, cin, sub, sat, 1'b1, acc);
        check_eq("accept", 64'(acc), 64'd1);
        drain();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic        acc;
        logic [31:0] va [10];
        logic [31:0] vb [10];
        logic        vsub [10];
        int          idx, c, n0, s0, w;

        bus.in_valid  = 1'b0;
        bus.a         = '0;
        bus.b         = '0;
        bus.cin       = 1'b0;
        bus.sub       = 1'b0;
        bus.sat       = 1'b0;
        bus.out_ready = 1'b1;
        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check_eq("rst_out_valid", 64'(bus.out_valid), 64'd0);
        check_eq("rst_y",         64'(bus.y),    64'd0);
        check_eq("rst_cout",      64'(bus.cout), 64'd0);
        check_eq("rst_ovf",       64'(bus.ovf),  64'd0);
        check_eq("rst_zero",      64'(bus.zero), 64'd0);
        check_eq("rst_neg",       64'(bus.neg),  64'd0);
        rst_n = 1'b1;

        // Scenario 1: signed overflow without saturation.
        run_one(32'h7FFF_FFFF, 32'd1, 1'b0, 1'b0, 1'b0);
        check_eq("s1_y",    64'(last_y),    64'h8000_0000);
        check_eq("s1_ovf",  64'(last_ovf),  64'd1);
        check_eq("s1_cout", 64'(last_cout), 64'd0);
        check_eq("s1_neg",  64'(last_neg),  64'd1);

        // Scenario 2: same with saturation.
        run_one(32'h7FFF_FFFF, 32'd1, 1'b0, 1'b0, 1'b1);
        check_eq("s2_y",   64'(last_y),   64'h7FFF_FFFF);
        check_eq("s2_ovf", 64'(last_ovf), 64'd1);
        check_eq("s2_neg", 64'(last_neg), 64'd0);

        // Scenario 3: carry ripples through every chunk.
        run_one(32'hFFFF_FFFF, 32'd0, 1'b1, 1'b0, 1'b0);
        check_eq("s3_y",    64'(last_y),    64'd0);
        check_eq("s3_zero", 64'(last_zero), 64'd1);
        check_eq("s3_cout", 64'(last_cout), 64'd1);
        check_eq("s3_ovf",  64'(last_ovf),  64'd0);

        // Scenario 4: subtraction, then negative saturation.
        run_one(32'd5, 32'd7, 1'b1, 1'b1, 1'b0);
        check_eq("s4a_y",    64'(last_y),    64'hFFFF_FFFE);
        check_eq("s4a_cout", 64'(last_cout), 64'd0);
        check_eq("s4a_ovf",  64'(last_ovf),  64'd0);
        check_eq("s4a_neg",  64'(last_neg),  64'd1);
        run_one(32'h8000_0000, 32'd1, 1'b0, 1'b1, 1'b1);
        check_eq("s4b_y",   64'(last_y),   64'h8000_0000);
        check_eq("s4b_ovf", 64'(last_ovf), 64'd1);

        // Scenario 5: 10 beats, one bubble, 3-cycle output stall.
        for (int i = 0; i < 10; i++) begin
            va[i]   = pick();
            vb[i]   = pick();
            vsub[i] = 1'($urandom_range(0, 1));
        end
        idx = 0;
        c   = 0;
        n0  = n_out;
        s0  = stalls;
        while (idx < 10 && c < 60) begin
            cycle((c != 3), va[idx], vb[idx], 1'($urandom_range(0, 1)), vsub[idx],
                  1'($urandom_range(0, 1)), !(c >= 6 && c <= 8), acc);
            if (acc) idx++;
            c++;
        end
        check_eq("s5_accepted", 64'(idx), 64'd10);
        drain();
        check_eq("s5_outputs", 64'(n_out - n0), 64'd10);
        check_eq("s5_stall_cycles", 64'(stalls - s0), 64'd3);

        // Randomized traffic with random back-pressure.
        for (int i = 0; i < 400; i++) begin
            cycle(($urandom_range(0, 4) != 0), pick(), pick(), 1'($urandom_range(0, 1)),
                  1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                  ($urandom_range(0, 3) != 0), acc);
        end
        drain();

        // Scenario 6: asynchronous reset with beats in flight.
        for (int i = 0; i < 6; i++) begin
            cycle(1'b1, pick(), pick(), 1'b0, 1'($urandom_range(0, 1)), 1'b0, 1'b1, acc);
        end
        check_eq("s6_pre_valid", 64'(bus.out_valid), 64'd1);
        bus.in_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        check_eq("s6_rst_valid", 64'(bus.out_valid), 64'd0);
        check_eq("s6_rst_y",     64'(bus.y),    64'd0);
        check_eq("s6_rst_cout",  64'(bus.cout), 64'd0);
        check_eq("s6_rst_ovf",   64'(bus.ovf),  64'd0);
        check_eq("s6_rst_zero",  64'(bus.zero), 64'd0);
        check_eq("s6_rst_neg",   64'(bus.neg),  64'd0);
        q.delete();
        hold_pend = 1'b0;
        @(negedge clk);
        cyc++;
        rst_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            check_eq("s6_quiet", 64'(bus.out_valid), 64'd0);
            idle();
        end
        n0 = n_out;
        cycle(1'b1, 32'h1234_5678, 32'h1111_1111, 1'b0, 1'b0, 1'b0, 1'b1, acc);
        w = 0;
        while (!bus.out_valid && w < 20) begin
            idle();
            w++;
        end
        check_eq("s6_latency", 64'(w + 1), 64'(K));
        drain();
        check_eq("s6_outputs", 64'(n_out - n0), 64'd1);
        check_eq("s6_y", 64'(last_y), 64'h2345_6789);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/adder_pipe.md
ADDER_PIPE -- requirements
Module: adder_pipe

Interface
REQ-001 The block SHALL have parameter N, default 32, giving the operand and result width in bits.
REQ-002 The block SHALL have parameter K, default 4, giving the number of carry-chain chunks and pipeline stages; N mod K SHALL be 0 and K SHALL be at least 1.
REQ-003 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 in_valid  input  1  operand beat present.
REQ-006 in_ready  output  1  block accepts a beat this cycle.
REQ-007 a  input  N  operand A.
REQ-008 b  input  N  operand B.
REQ-009 cin  input  1  carry-in; used by add only.
REQ-010 sub  input  1  0 = add, 1 = subtract.
REQ-011 sat  input  1  1 = signed saturation on overflow.
REQ-012 out_valid  output  1  result beat present.
REQ-013 out_ready  input  1  downstream accepts the result.
REQ-014 y  output  N  result.
REQ-015 cout  output  1  raw carry out of bit N-1.
REQ-016 ovf  output  1  signed overflow.
REQ-017 zero  output  1  y == 0, evaluated after saturation.
REQ-018 neg  output  1  y[N-1], evaluated after saturation.

Function
REQ-019 Operand preparation SHALL be: add gives b_eff = b and c0 = cin; sub gives b_eff = ~b and c0 = 1, with cin ignored.
REQ-020 The raw sum SHALL be {cout, s} = a + b_eff + c0, computed modulo 2^(N+1).
REQ-021 Stage i (i = 0..K-1) SHALL add chunk i of a and b_eff, each W = N/K bits, using the carry registered out of stage i-1 (c0 for stage 0).
REQ-022 Operand chunks for stage i SHALL be delayed i cycles and completed result chunks SHALL be held until all K chunks are available.
REQ-023 ovf SHALL equal (a[N-1] & b_eff[N-1] & ~s[N-1]) | (~a[N-1] & ~b_eff[N-1] & s[N-1]).
REQ-024 With sat = 1 and ovf = 1, y SHALL be 0 followed by all 1s when a[N-1] = 0, else 1 followed by all 0s; otherwise y SHALL equal s.
REQ-025 With sat = 1, cout and ovf SHALL still report the raw values.
REQ-026 sub, sat, and the a/b_eff sign bits SHALL travel with their beat through the pipeline.
REQ-027 The global advance signal SHALL be adv = ~out_valid | out_ready, and every stage register, including the valid bits, SHALL load only when adv = 1.
REQ-028 in_ready SHALL equal adv; a beat SHALL be accepted when in_valid & in_ready.
REQ-029 Latency SHALL be exactly K cycles from acceptance to out_valid when adv stays 1, and throughput SHALL be one beat per cycle.
REQ-030 Bubbles, cycles with in_valid = 0, SHALL propagate as invalid stages and SHALL NOT corrupt neighbouring beats.
REQ-031 While out_valid = 1 and out_ready = 0, y, cout, ovf, zero, neg and out_valid SHALL hold stable and in_ready SHALL be 0.
REQ-032 Beats SHALL exit in acceptance order with no loss or duplication.
REQ-033 Input payload SHALL be ignored when in_valid = 0 or in_ready = 0.
REQ-034 With K = 1, the block SHALL be one registered stage with latency 1.

Reset
REQ-035 When rst_n = 0, all valid bits, out_valid, y, cout, ovf, zero and neg SHALL go to 0 immediately, independent of clk.
REQ-036 Reset asserted mid-operation SHALL discard all in-flight beats.
REQ-037 The first beat accepted after reset is released SHALL be the first output.
REQ-038 Data-path registers other than the outputs need not be reset, but no stale value SHALL ever appear with out_valid = 1.

Verification (N = 32, K = 4, out_ready = 1 unless stated)
REQ-039 Scenario 1: a = 0x7FFFFFFF, b = 1, add, cin = 0, sat = 0 -> 4 cycles later y = 0x80000000, ovf = 1, cout = 0, neg = 1.
REQ-040 Scenario 2: same operands with sat = 1 -> y = 0x7FFFFFFF, ovf = 1, neg = 0.
REQ-041 Scenario 3: a = 0xFFFFFFFF, b = 0, add, cin = 1, so the carry ripples through all 4 chunks -> y = 0, zero = 1, cout = 1, ovf = 0.
REQ-042 Scenario 4: a = 5, b = 7, sub -> y = 0xFFFFFFFE, cout = 0, ovf = 0, neg = 1; a = 0x80000000, b = 1, sub, sat = 1 -> y = 0x80000000, ovf = 1.
REQ-043 Scenario 5: 10 back-to-back beats with one bubble, and out_ready = 0 for 3 cycles while out_valid = 1 -> in_ready = 0 during the stall, outputs held, all 10 results correct and in order.
REQ-044 Scenario 6: rst_n pulsed low between clock edges with 3 beats in flight -> out_valid = 0 at once and none of the 3 beats appear after release; the next accepted beat emerges after 4 cycles.
